// File: rtl/data_store_buffer.sv
// Store buffer between a single-cycle core and a slow req/ack data memory.
// Optional STORE_FWD_EN macro enables forwarding of buffered stores to loads.
module data_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    input  logic                    cpu_wen,
    input  logic                    cpu_ren,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    cpu_stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_ack,
    output logic [$clog2(DEPTH):0]  buf_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    state_t state;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              drain_ack;
    logic              read_ack;
    logic              full;
    logic              store_stall;
    logic              enq;
    logic              load_miss;
    logic              load_stall;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    assign drain_ack   = (state == WRITE) && mem_ack;
    assign read_ack    = (state == READ) && mem_ack;
    assign full        = (count == CNT_W'(DEPTH));
    // A slot freed by this cycle's drain ack is immediately reusable.
    assign store_stall = cpu_wen && full && !drain_ack;
    assign enq         = cpu_wen && !store_stall;
    assign load_miss   = cpu_ren && !cpu_wen && !hit;
    assign load_stall  = load_miss && !read_ack;
    assign buf_count   = count;

`ifdef STORE_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        fwd_idx  = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) &&
                (addr_q[fwd_idx][ADDR_W-1:2] == cpu_addr[ADDR_W-1:2])) begin
                hit      = 1'b1;
                hit_data = data_q[fwd_idx];
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        if (!reset) begin
            cpu_stall = store_stall || load_stall;
            if (read_ack) begin
                cpu_rdata = mem_rdata;
            end else if (cpu_ren && hit) begin
                cpu_rdata = hit_data;
            end
        end
    end

    // Entry storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (enq) begin
            addr_q[tail] <= cpu_addr;
            data_q[tail] <= cpu_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (drain_ack) begin
                head <= head + PTR_W'(1);
            end
            if (enq && !drain_ack) begin
                count <= count + CNT_W'(1);
            end else if (!enq && drain_ack) begin
                count <= count - CNT_W'(1);
            end

            // Buffered stores always go first so a read sees every older store.
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q[head];
                        mem_wdata <= data_q[head];
                        state     <= WRITE;
                    end else if (load_miss) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= cpu_addr;
                        state    <= READ;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_store_buffer.sv
// Scoreboard bench for data_store_buffer: stores and loads push expectations,
// monitors compare memory writes and load data as the DUT presents them.
module tb_data_store_buffer;
    localparam int TMO = 200;

    logic        clock;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_wen;
    logic        cpu_ren;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [2:0]  buf_count;

    int total = 0;
    int bad   = 0;
    int budget = 0;
    bit stray  = 0;

    logic [63:0] wq[$];
    logic [31:0] lq[$];
    logic [31:0] mdl[logic [31:0]];

    data_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wen(cpu_wen), .cpu_ren(cpu_ren),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .buf_count(buf_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endfunction

    // Memory model: acks while budget allows, one ack per transaction.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clock); #1;
            if (reset) begin
                mem_ack = 1'b0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (stray) begin
                mem_ack = 1'b1;
                stray   = 1'b0;
            end else if (mem_req && budget > 0) begin
                budget--;
                mem_ack = 1'b1;
                if (mem_we) mdl[mem_addr] = mem_wdata;
                else mem_rdata = mdl.exists(mem_addr) ? mdl[mem_addr] : 32'h0;
            end
        end
    end

    // Memory-side monitor: write order/content and read ordering.
    always @(negedge clock) begin
        if (!reset && mem_req && mem_ack) begin
            if (mem_we) begin
                if (wq.size() == 0) begin
                    chk("write_unexpected", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    logic [63:0] e;
                    e = wq.pop_front();
                    chk("write_addr", mem_addr, e[63:32]);
                    chk("write_data", mem_wdata, e[31:0]);
                end
            end else begin
                chk("read_after_drain", 32'(wq.size()), 32'd0);
            end
        end
    end

    // Core-side monitor: load data whenever a load completes.
    always @(negedge clock) begin
        if (!reset && cpu_ren && !cpu_wen && !cpu_stall) begin
            if (lq.size() == 0) chk("load_unexpected", cpu_rdata, 32'hFFFF_FFFF);
            else chk("load_data", cpu_rdata, lq.pop_front());
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
        bit ok = 0;
        @(posedge clock); #1;
        cpu_addr = a; cpu_wdata = d; cpu_wen = 1'b1; cpu_ren = 1'b0;
        stalls = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clock);
            if (!cpu_stall) begin ok = 1; break; end
            stalls++;
        end
        if (ok) wq.push_back({a, d});
        else chk("store_timeout", 32'(stalls), 32'd0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp, output int stalls);
        bit ok = 0;
        lq.push_back(exp);
        @(posedge clock); #1;
        cpu_addr = a; cpu_wen = 1'b0; cpu_ren = 1'b1;
        stalls = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clock);
            if (!cpu_stall) begin ok = 1; break; end
            stalls++;
        end
        if (!ok) chk("load_timeout", 32'(stalls), 32'd0);
    endtask

    task automatic release_bus();
        @(posedge clock); #1;
        cpu_wen = 1'b0; cpu_ren = 1'b0;
    endtask

    task automatic wait_drain(input string n);
        bit ok = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clock);
            if (buf_count == 3'd0 && !mem_req && wq.size() == 0) begin ok = 1; break; end
        end
        chk(n, 32'(ok), 32'd1);
    endtask

    initial begin
        int st;
        reset = 1'b1; cpu_addr = 32'h100; cpu_wdata = '0; cpu_wen = 1'b0; cpu_ren = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_count", 32'(buf_count), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        cpu_ren = 1'b0;
        @(negedge clock); reset = 1'b0;

        // Single store with a one-cycle memory.
        budget = 1000;
        do_store(32'h10, 32'hDEADBEEF, st);
        chk("t1_stall", 32'(st), 32'd0);
        release_bus();
        @(negedge clock);
        chk("t1_count1", 32'(buf_count), 32'd1);
        @(negedge clock);
        chk("t1_req", 32'(mem_req), 32'd1);
        chk("t1_we", 32'(mem_we), 32'd1);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clock);
        chk("t1_count0", 32'(buf_count), 32'd0);
        wait_drain("t1_drain");

        // Fill to DEPTH with acks withheld, fifth store waits for one ack.
        budget = 0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'(i * 4), 32'hA0 + 32'(i), st);
            chk("t2_nostall", 32'(st), 32'd0);
        end
        fork
            do_store(32'h10, 32'hA4, st);
            begin
                repeat (3) begin
                    @(negedge clock);
                    chk("t2_full_stall", 32'(cpu_stall), 32'd1);
                    chk("t2_full_count", 32'(buf_count), 32'd4);
                end
                budget = 1;
                @(negedge clock);
                chk("t2_ack", 32'(mem_ack), 32'd1);
                chk("t2_accept", 32'(cpu_stall), 32'd0);
            end
        join
        chk("t2_stall_cycles", 32'(st), 32'd3);
        release_bus();
        @(negedge clock);
        chk("t2_count_after", 32'(buf_count), 32'd4);
        budget = 1000;
        wait_drain("t2_drain");

        // Two stores to one address, then a load of it.
        budget = 0;
        do_store(32'h20, 32'h1111, st);
        do_store(32'h20, 32'h2222, st);
        fork
            do_load(32'h20, 32'h2222, st);
            begin repeat (4) @(negedge clock); budget = 1000; end
        join
`ifdef STORE_FWD_EN
        chk("t3_fwd_nostall", 32'(st), 32'd0);
`else
        chk("t3_stalled", 32'(st > 0), 32'd1);
`endif
        release_bus();
        wait_drain("t3_drain");

        // Load miss behind an outstanding store.
        budget = 0;
        mdl[32'h40] = 32'hABCD;
        do_store(32'h30, 32'h5, st);
        budget = 1000;
        do_load(32'h40, 32'hABCD, st);
        chk("t4_stalled", 32'(st > 0), 32'd1);
        release_bus();
        wait_drain("t4_drain");
        chk("t4_mem30", mdl[32'h30], 32'h5);

        // Minimum miss latency from an empty buffer.
        mdl[32'h44] = 32'h4444;
        do_load(32'h44, 32'h4444, st);
        chk("t4_min_latency", 32'(st), 32'd1);
        release_bus();

        // Reset in the middle of an outstanding write.
        budget = 0;
        do_store(32'h50, 32'h1, st);
        do_store(32'h54, 32'h2, st);
        do_store(32'h58, 32'h3, st);
        release_bus();
        repeat (2) @(negedge clock);
        chk("t5_count3", 32'(buf_count), 32'd3);
        chk("t5_req_out", 32'(mem_req), 32'd1);
        @(posedge clock); #1;
        cpu_addr = 32'h9C; cpu_ren = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("t5_async_req", 32'(mem_req), 32'd0);
        chk("t5_async_we", 32'(mem_we), 32'd0);
        chk("t5_async_addr", mem_addr, 32'd0);
        chk("t5_async_wdata", mem_wdata, 32'd0);
        chk("t5_async_count", 32'(buf_count), 32'd0);
        chk("t5_async_stall", 32'(cpu_stall), 32'd0);
        chk("t5_async_rdata", cpu_rdata, 32'd0);
        @(negedge clock);
        cpu_ren = 1'b0;
        wq.delete();
        @(negedge clock); reset = 1'b0;
        stray = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("t5_stray_req", 32'(mem_req), 32'd0);
            chk("t5_stray_count", 32'(buf_count), 32'd0);
        end
        budget = 1000;
        do_store(32'h60, 32'h77, st);
        release_bus();
        wait_drain("t5_drain");
        chk("t5_mem50_untouched", 32'(mdl.exists(32'h50)), 32'd0);
        do_load(32'h60, 32'h77, st);
        release_bus();
        repeat (2) @(negedge clock);
        chk("loads_all_seen", 32'(lq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
